// File: rtl/t1b_ultrasonic_pkg.sv
// Shared types and constants for the HC-SR04-style ranger controller.
// The optional echo timeout is enabled by defining T1B_ECHO_TIMEOUT_EN.
package t1b_ultrasonic_pkg;

   localparam int COUNT_W = 20;
   localparam int DIST_W  = 16;
   localparam int PROD_W  = 29;

   localparam int PERIOD_CYC_DEF   = 600555;
   localparam int TRIG_START_DEF   = 52;
   localparam int TRIG_LEN_DEF     = 500;
   localparam int OBSTACLE_MM_DEF  = 70;
   localparam int MAX_ECHO_CYC_DEF = 500000;

   // 2 ms round trip corresponds to roughly 339 mm
   localparam int SCALE_NUM = 339;
   localparam int SCALE_DEN = 100000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } state_e;

   function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

endpackage

// File: rtl/t1b_dist_scale.sv
// Combinational echo-width to millimetre conversion: floor(count * 339 / 100000).
// Product fits in 29 bits; the quotient always fits in the 16-bit distance.
module t1b_dist_scale
   import t1b_ultrasonic_pkg::*;
(
   input  logic [COUNT_W-1:0] count,
   output logic [DIST_W-1:0]  dist_mm
);

   logic [PROD_W-1:0] prod;

   assign prod    = PROD_W'(count) * PROD_W'(SCALE_NUM);
   assign dist_mm = DIST_W'(prod / PROD_W'(SCALE_DEN));

endmodule

// File: rtl/t1b_ultrasonic.sv
// Ultrasonic ranger: periodic 10 us trigger, echo width capture, mm conversion, obstacle flag.
// Define T1B_ECHO_TIMEOUT_EN to abort over-long echoes at MAX_ECHO_CYC cycles.
module t1b_ultrasonic
   import t1b_ultrasonic_pkg::*;
#(
   parameter int PERIOD_CYC  = PERIOD_CYC_DEF,
   parameter int TRIG_START  = TRIG_START_DEF,
   parameter int TRIG_LEN    = TRIG_LEN_DEF,
   parameter int OBSTACLE_MM = OBSTACLE_MM_DEF
`ifdef T1B_ECHO_TIMEOUT_EN
   ,
   parameter int MAX_ECHO_CYC = MAX_ECHO_CYC_DEF
`endif
)(
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              echo_rx,
   output logic              trig,
   output logic              op,
   output logic [DIST_W-1:0] distance_out
);

   localparam int PC_W = $clog2(PERIOD_CYC);

   localparam logic [1:0] S_IDLE    = IDLE;
   localparam logic [1:0] S_ARM     = ARM;
   localparam logic [1:0] S_MEASURE = MEASURE;

   localparam logic [PC_W-1:0] PC_LAST  = PC_W'(PERIOD_CYC - 1);
   localparam logic [PC_W-1:0] PC_TRIG0 = PC_W'(TRIG_START);
   localparam logic [PC_W-1:0] PC_TRIG1 = PC_W'(TRIG_START + TRIG_LEN - 1);
   localparam logic [PC_W-1:0] PC_ARM   = PC_W'(TRIG_START + TRIG_LEN);

   logic [PC_W-1:0]    pc, pc_nxt;
   logic               trig_nxt;
   logic [1:0]         state;
   logic [COUNT_W-1:0] count;
   logic [DIST_W-1:0]  scaled;

   function automatic logic is_obstacle(input logic [DIST_W-1:0] d);
      return (d != '0) && (d < DIST_W'(OBSTACLE_MM));
   endfunction

   // trig and the FSM key off the counter value the edge is about to load
   always_comb begin
      pc_nxt   = (pc == PC_LAST) ? '0 : pc + 1'b1;
      trig_nxt = (pc_nxt >= PC_TRIG0) && (pc_nxt <= PC_TRIG1);
   end

   t1b_dist_scale u_scale (
      .count   (count),
      .dist_mm (scaled)
   );

   always_ff @(posedge clk_50M or negedge reset) begin
      if (!reset) begin
         pc           <= '0;
         trig         <= 1'b0;
         state        <= S_IDLE;
         count        <= '0;
         distance_out <= '0;
         op           <= 1'b0;
      end else begin
         pc   <= pc_nxt;
         trig <= trig_nxt;
         case (state)
            S_IDLE: begin
               if (pc_nxt == PC_ARM) state <= S_ARM;
            end
            S_ARM: begin
               if (echo_rx) begin
                  count <= COUNT_W'(1);
                  state <= S_MEASURE;
               end else begin
                  distance_out <= '0;
                  op           <= 1'b0;
                  state        <= S_IDLE;
               end
            end
            S_MEASURE: begin
`ifdef T1B_ECHO_TIMEOUT_EN
               if (echo_rx && (count >= COUNT_W'(MAX_ECHO_CYC))) begin
                  distance_out <= '0;
                  op           <= 1'b0;
                  state        <= S_IDLE;
               end else
`endif
               // echo fall or window end both latch the width seen so far
               if (!echo_rx || (pc_nxt == '0)) begin
                  distance_out <= scaled;
                  op           <= is_obstacle(scaled);
                  state        <= S_IDLE;
               end else begin
                  count <= sat_inc(count);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_t1b_ultrasonic.sv
// Directed bench for t1b_ultrasonic with a shortened period and obstacle threshold.
module tb_t1b_ultrasonic;

   localparam int P   = 6500;
   localparam int OBS = 20;

   logic        clk_50M = 1'b0;
   logic        reset   = 1'b0;
   logic        echo_rx = 1'b0;
   logic        trig;
   logic        op;
   logic [15:0] distance_out;

   int checks = 0;
   int errors = 0;
   int edges  = 0;
   int cur_d  = 0;
   int cur_op = 0;

   always #10 clk_50M = ~clk_50M;

   t1b_ultrasonic #(
      .PERIOD_CYC  (P),
      .TRIG_START  (52),
      .TRIG_LEN    (500),
      .OBSTACLE_MM (OBS)
   ) dut (
      .clk_50M      (clk_50M),
      .reset        (reset),
      .echo_rx      (echo_rx),
      .trig         (trig),
      .op           (op),
      .distance_out (distance_out)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_50M);
      #1;
      edges++;
   endtask

   task automatic to_pc(input int tgt);
      while ((edges % P) != tgt) step();
   endtask

   // One full period from pc=0: trigger shape, hold across trigger, echo of len cycles.
   task automatic run_period(input string tag, input int len, input int d, input int o);
      to_pc(51);
      chk({tag, ".trig_pre"}, 32'(trig), 0);
      step();
      chk({tag, ".trig_rise"}, 32'(trig), 1);
      to_pc(551);
      chk({tag, ".trig_last"}, 32'(trig), 1);
      step();
      chk({tag, ".trig_fall"}, 32'(trig), 0);
      chk({tag, ".hold_d"}, 32'(distance_out), cur_d);
      chk({tag, ".hold_op"}, 32'(op), cur_op);
      if (len > 0) begin
         echo_rx = 1'b1;
         repeat (len) step();
         echo_rx = 1'b0;
         chk({tag, ".pre_d"}, 32'(distance_out), cur_d);
      end
      step();
      chk({tag, ".dist"}, 32'(distance_out), d);
      chk({tag, ".op"}, 32'(op), o);
      cur_d  = d;
      cur_op = o;
      to_pc(0);
   endtask

   initial begin
      #5;
      chk("rst.trig", 32'(trig), 0);
      chk("rst.dist", 32'(distance_out), 0);
      chk("rst.op", 32'(op), 0);
      @(negedge clk_50M);
      reset = 1'b1;

      repeat (51) begin
         step();
         chk("p0.trig_low", 32'(trig), 0);
      end
      run_period("p0", 0, 0, 0);
      run_period("p1", 5900, 20, 0);   // 20.001 -> 20, not below threshold
      run_period("p2", 5000, 16, 1);
      run_period("p3", 2950, 10, 1);   // 10.0005 truncates
      run_period("p4", 295, 1, 1);
      run_period("p5", 294, 0, 0);     // zero distance is never an obstacle
      run_period("p6", 4000, 13, 1);

      // echo while idle must be ignored
      to_pc(10);
      echo_rx = 1'b1;
      to_pc(40);
      echo_rx = 1'b0;
      run_period("p7", 0, 0, 0);

      // echo held through the window end latches count 5947 -> 20 mm
      to_pc(52);
      chk("p8.trig_rise", 32'(trig), 1);
      to_pc(552);
      chk("p8.trig_fall", 32'(trig), 0);
      echo_rx = 1'b1;
      to_pc(P - 1);
      chk("p8.pre_wrap", 32'(distance_out), 0);
      step();
      chk("p8.wrap_d", 32'(distance_out), 20);
      chk("p8.wrap_op", 32'(op), 0);
      to_pc(30);
      echo_rx = 1'b0;
      chk("p8.hold_d", 32'(distance_out), 20);
      cur_d  = 20;
      cur_op = 0;

      // asynchronous reset in the middle of a measurement
      to_pc(552);
      echo_rx = 1'b1;
      repeat (100) step();
      #3 reset = 1'b0;
      #1;
      chk("arst.trig", 32'(trig), 0);
      chk("arst.dist", 32'(distance_out), 0);
      chk("arst.op", 32'(op), 0);
      echo_rx = 1'b0;
      @(posedge clk_50M);
      #1;
      chk("arst.hold_d", 32'(distance_out), 0);
      @(negedge clk_50M);
      reset  = 1'b1;
      edges  = 0;
      cur_d  = 0;
      cur_op = 0;
      run_period("p9", 1000, 3, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
